flow_queue: RTL and testbench



---
 rtl/flow_queue_if.sv | 24 ++
 rtl/flow_queue.sv | 93 +++++++++
 tb/tb_flow_queue.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/flow_queue_if.sv
// Valid/ready item channel for flow_queue: producer side (i_*) and consumer side (o_*).
// The queue connects through the slave modport; the environment uses master.
interface flow_queue_if #(
    parameter int W = 1
);
    // Handshake: a transfer completes on a posedge where valid and ready are both high.
    // Valid must not depend on ready; the payload is meaningful only while valid is high.
    logic         i_v;
    logic         i_rdy;
    logic [W-1:0] i;
    logic         o_v;
    logic         o_rdy;
    logic [W-1:0] o;

    modport slave (
        input  i_v, i, o_rdy,
        output i_rdy, o_v, o
    );

    modport master (
        output i_v, i, o_rdy,
        input  i_rdy, o_v, o
    );
endinterface

// File: rtl/flow_queue.sv
// Elastic valid/ready FIFO of N items (any N >= 1) with occupancy count, thresholds,
// flush and clock-enable. Optional same-cycle bypass when empty: FLOW_QUEUE_BYPASS_EN.
module flow_queue #(
    parameter int W  = 1,
    parameter int N  = 2,
    parameter int AF = N,
    parameter int AE = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clk_en,
    input  logic                   flush,
    flow_queue_if.slave            q,
    output logic [$clog2(N+1)-1:0] count,
    output logic                   almost_full,
    output logic                   almost_empty
);
    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(N + 1);

    function automatic bit params_ok(input int w, input int n, input int af, input int ae);
        return (w >= 1) && (n >= 1) && (af >= 1) && (af <= n) && (ae >= 0) && (ae < n);
    endfunction

    if (!params_ok(W, N, AF, AE)) begin : g_bad_params
        $error("flow_queue: illegal parameters W=%0d N=%0d AF=%0d AE=%0d", W, N, AF, AE);
    end

    function automatic logic [AW-1:0] next_ad(input logic [AW-1:0] a);
        return (a == AW'(N - 1)) ? '0 : a + AW'(1);
    endfunction

    logic [W-1:0]  ram [N];
    logic [AW-1:0] rd_ad;
    logic [AW-1:0] wr_ad;
    logic [CW-1:0] count_q;
    logic          full;
    logic          empty;
    logic          active;
    logic          enq;
    logic          deq;

    assign full   = (count_q == CW'(N));
    assign empty  = (count_q == '0);
    assign active = clk_en && !flush;

    // i_rdy depends only on stored occupancy, so a full queue refuses input even when
    // the head leaves in the same cycle; this keeps o_rdy off the i_rdy path.
    assign q.i_rdy = active && !full;

`ifdef FLOW_QUEUE_BYPASS_EN
    logic bypass;
    assign bypass = active && empty && q.i_v;
    assign q.o_v  = (active && !empty) || bypass;
    assign q.o    = empty ? q.i : ram[rd_ad];
    // A bypassed item taken immediately never touches storage.
    assign enq    = q.i_v && q.i_rdy && !(bypass && q.o_rdy);
    assign deq    = q.o_v && q.o_rdy && !empty;
`else
    assign q.o_v  = active && !empty;
    assign q.o    = ram[rd_ad];
    assign enq    = q.i_v && q.i_rdy;
    assign deq    = q.o_v && q.o_rdy;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ad   <= '0;
            wr_ad   <= '0;
            count_q <= '0;
        end else if (clk_en) begin
            if (flush) begin
                rd_ad   <= '0;
                wr_ad   <= '0;
                count_q <= '0;
            end else begin
                if (enq) wr_ad <= next_ad(wr_ad);
                if (deq) rd_ad <= next_ad(rd_ad);
                if (enq && !deq)      count_q <= count_q + CW'(1);
                else if (deq && !enq) count_q <= count_q - CW'(1);
            end
        end
    end

    // Storage has no reset; contents are only ever read behind a valid count.
    always_ff @(posedge clk) begin
        if (enq) ram[wr_ad] <= q.i;
    end

    assign count        = count_q;
    assign almost_full  = (count_q >= CW'(AF));
    assign almost_empty = (count_q <= CW'(AE));
endmodule

// File: tb/tb_flow_queue.sv
// Randomized and directed bench for flow_queue (N=3, W=8) against a queue-based model.
// Each step drives inputs at negedge, checks outputs before the posedge, then updates the model.
module tb_flow_queue;
    localparam int W  = 8;
    localparam int N  = 3;
    localparam int AF = 2;
    localparam int AE = 1;
    localparam int CW = $clog2(N + 1);
`ifdef FLOW_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          clk_en;
    logic          flush;
    logic [CW-1:0] count;
    logic          almost_full;
    logic          almost_empty;

    flow_queue_if #(.W(W)) qif ();

    flow_queue #(.W(W), .N(N), .AF(AF), .AE(AE)) dut (
        .clk          (clk),
        .rst          (rst),
        .clk_en       (clk_en),
        .flush        (flush),
        .q            (qif.slave),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard
    logic [W-1:0] exp_q[$];
    int err_cnt = 0;
    int chk_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive, check outputs against the model, advance the model on the edge.
    task automatic step(input logic r, input logic en, input logic fl, input logic iv,
                        input logic [W-1:0] din, input logic ordy);
        int   size;
        logic e_rdy, e_ov, byp, take, put;
        logic [W-1:0] e_o;
        @(negedge clk);
        rst       = r;
        clk_en    = en;
        flush     = fl;
        qif.i_v   = iv;
        qif.i     = din;
        qif.o_rdy = ordy;
        #1;
        size  = exp_q.size();
        e_rdy = en && !fl && (size < N);
        byp   = BYP && (size == 0) && iv && en && !fl;
        e_ov  = (en && !fl && (size > 0)) || byp;
        e_o   = (size > 0) ? exp_q[0] : din;
        check("count", 32'(count), 32'(size));
        check("almost_full", 32'(almost_full), 32'(size >= AF));
        check("almost_empty", 32'(almost_empty), 32'(size <= AE));
        if (!r) begin
            check("i_rdy", 32'(qif.i_rdy), 32'(e_rdy));
            check("o_v", 32'(qif.o_v), 32'(e_ov));
            if (e_ov) check("o", 32'(qif.o), 32'(e_o));
        end
        @(posedge clk);
        if (r || (en && fl)) begin
            exp_q.delete();
        end else begin
            take = e_ov && ordy;
            put  = iv && e_rdy;
            if (!(byp && take)) begin
                if (take) void'(exp_q.pop_front());
                if (put)  exp_q.push_back(din);
            end
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic push(input logic [W-1:0] d);
        step(1'b0, 1'b1, 1'b0, 1'b1, d, 1'b0);
    endtask

    task automatic pop();
        step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1);
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b1; flush = 1'b0;
        qif.i_v = 1'b0; qif.i = '0; qif.o_rdy = 1'b0;

        step(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        idle();
        check("reset_i_rdy", 32'(qif.i_rdy), 32'd1);

        // non-power-of-two fill and drain
        push(8'h11); push(8'h22); push(8'h33);
        idle();
        check("fill_count", 32'(count), 32'd3);
        check("fill_i_rdy", 32'(qif.i_rdy), 32'd0);
        check("fill_af", 32'(almost_full), 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h44, 1'b0);
        pop(); pop(); pop();
        idle();
        check("drain_count", 32'(count), 32'd0);

        // full with simultaneous dequeue: one leaves, none enters
        push(8'hA1); push(8'hA2); push(8'hA3);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'hA4, 1'b1);
        idle();
        check("full_deq_count", 32'(count), 32'd2);
        check("full_deq_i_rdy", 32'(qif.i_rdy), 32'd1);
        pop(); pop();

        // wrap-around with continuous traffic
        for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 1'b0, 1'b1, 8'(k), 1'b1);
        pop(); pop(); idle();

        // flush mid-stream with a competing input
        push(8'h51); push(8'h52);
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h53, 1'b1);
        check("flush_i_rdy", 32'(qif.i_rdy), 32'd0);
        idle();
        check("flush_count", 32'(count), 32'd0);
        check("flush_ae", 32'(almost_empty), 32'd1);

        // stall
        push(8'h61);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, 1'b1, 8'h62, 1'b1);
        check("stall_count", 32'(count), 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h63, 1'b1);
        pop(); idle();

        // empty queue, item offered and consumer ready
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1);
        check("bypass_o_v", 32'(qif.o_v), 32'(BYP));
        idle();
        pop(); idle();

        // reset wins over stalled clock enable and flush
        push(8'h71); push(8'h72);
        step(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        idle();
        check("midrst_count", 32'(count), 32'd0);

        // randomized traffic
        for (int k = 0; k < 600; k++) begin
            step(1'($urandom_range(0, 99) < 2),
                 1'($urandom_range(0, 99) < 90),
                 1'($urandom_range(0, 99) < 4),
                 1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 99) < 45));
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
